// File: rtl/fan_cfg_sequencer.sv
// Configuration sequencer for a row of reduction-network adder switches.
// Streams one table entry per non-stalled cycle, drains the switch pipeline, then pulses done.
module fan_cfg_sequencer #(
    parameter int unsigned NUM_SW = 8,
    parameter int unsigned SEL_IN = 2,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned LAT    = 2,
    localparam int unsigned SW_W  = 4 + SEL_IN,
    localparam int unsigned CW    = NUM_SW * SW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cfg_we,
    input  logic [AW-1:0]            i_cfg_waddr,
    input  logic [CW-1:0]            i_cfg_wdata,
    input  logic                     i_start,
    input  logic [AW:0]              i_num_entries,
    input  logic                     i_stall,
    output logic                     o_valid,
    output logic [NUM_SW-1:0]        o_add_en,
    output logic [3*NUM_SW-1:0]      o_cmd,
    output logic [SEL_IN*NUM_SW-1:0] o_sel,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [AW-1:0]            o_entry_idx
);

    localparam int unsigned DW = $clog2(LAT + 2);
    localparam logic [AW:0] MAX_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q;
    logic [AW:0]     n_q;
    logic [DW-1:0]   drain_q;
    logic [CW-1:0]   cfg_q;
    logic [CW-1:0]   mem_q [DEPTH];

    logic [AW:0]     n_clamp;
    logic            last_issue;
    logic            cfg_wr;
    logic            start_acc;

    assign n_clamp    = (i_num_entries > MAX_N) ? MAX_N : i_num_entries;
    assign last_issue = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
    assign cfg_wr     = i_cfg_we && ((state_q == StIdle) || (state_q == StDone));
    assign start_acc  = (state_q == StIdle) && i_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = (n_clamp == '0) ? StDone : StIssue;
            StIssue: if (!i_stall && last_issue) state_d = StDrain;
            StDrain: if (drain_q == DW'(LAT)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_valid = (state_q == StIssue) && !i_stall;
        o_busy  = (state_q == StIssue) || (state_q == StDrain);
        o_done  = (state_q == StDone);
    end

    // Config outputs lag the issue by one cycle to match the switch's registered i_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            n_q     <= '0;
            drain_q <= '0;
            cfg_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cfg_q   <= o_valid ? mem_q[idx_q] : '0;
            drain_q <= (state_q == StDrain) ? drain_q + DW'(1) : '0;
            if (cfg_wr) begin
                mem_q[i_cfg_waddr] <= i_cfg_wdata;
            end
            if (start_acc) begin
                n_q   <= n_clamp;
                idx_q <= '0;
            end else if (o_valid) begin
                idx_q <= idx_q + AW'(1);
            end
        end
    end

    for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
        assign o_sel[j*SEL_IN +: SEL_IN] = cfg_q[j*SW_W +: SEL_IN];
        assign o_cmd[j*3 +: 3]           = cfg_q[j*SW_W + SEL_IN +: 3];
        assign o_add_en[j]               = cfg_q[j*SW_W + SEL_IN + 3];
    end

    assign o_entry_idx = idx_q;

endmodule

// File: doc/fan_cfg_sequencer.md
Name: fan_cfg_sequencer

Overview:
- Drives per-fold reconfiguration of a row of NUM_SW adder switches (edge and interior) in the reduction network.
- Holds a small configuration table, one entry per fold, each entry carrying add_en/cmd/sel for every switch.
- On start, streams entries to the switches one per cycle, respecting downstream stall, then drains the switch pipeline and signals done.
- Timing matches switch behaviour: a switch registers i_valid and consumes i_cmd/i_sel/i_add_en one cycle later.

Parameters:
- NUM_SW, 8, number of adder switches controlled.
- SEL_IN, 2, reduction-mux select width per switch.
- DEPTH, 16, configuration table entries.
- AW, 4, table address width (log2 DEPTH).
- LAT, 2, cycles from the last applied config to the final switch output being valid.
- CW, derived, NUM_SW*(4+SEL_IN); per-switch field order (MSB..LSB) is add_en, cmd[2:0], sel.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_cfg_we  in  1  table write enable
- i_cfg_waddr  in  AW  table write address
- i_cfg_wdata  in  CW  entry data; switch j occupies bits [(j+1)*(4+SEL_IN)-1 : j*(4+SEL_IN)]
- i_start  in  1  start pulse
- i_num_entries  in  AW+1  entries to issue (0..DEPTH), sampled on accepted start
- i_stall  in  1  downstream back-pressure; no issue this cycle
- o_valid  out  1  data-valid to switches
- o_add_en  out  NUM_SW  per-switch add enable
- o_cmd  out  3*NUM_SW  per-switch command
- o_sel  out  SEL_IN*NUM_SW  per-switch mux select
- o_busy  out  1  high in ISSUE/DRAIN
- o_done  out  1  one-cycle completion pulse
- o_entry_idx  out  AW  index of next entry to issue

Behaviour:
- Reset: all outputs 0, state IDLE, idx 0, drain counter 0, table cleared to 0. Reset mid-operation aborts immediately, with no o_done.
- Table write: in IDLE or DONE, i_cfg_we writes i_cfg_wdata at i_cfg_waddr on the clock edge. Writes while o_busy are ignored.
- IDLE: i_start=1 latches N=i_num_entries and idx=0. If N=0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - In each cycle with i_stall=0, o_valid=1 and entry idx is issued, then idx increments.
  - After issuing idx=N-1, go to DRAIN.
  - i_stall=1: o_valid=0, idx holds.
- Config lag: o_add_en/o_cmd/o_sel at cycle t+1 equal the entry issued at cycle t (o_valid=1 at t). If o_valid=0 at t, they are all 0 at t+1 (cmd 000 = no operation).
- DRAIN: waits LAT+1 cycles (one config-lag cycle plus LAT); i_stall is ignored. Then go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. i_start in the DONE cycle is ignored.
- i_start while busy is ignored. N>DEPTH is clamped to DEPTH.
- Simultaneous i_start and i_cfg_we in IDLE: the write completes, and the new data is visible if its address is issued (issue starts the cycle after start).
- o_entry_idx = idx. Table reads are combinational from registers.
- Latency: start at cycle 0 -> first o_valid at cycle 1 -> o_done at cycle N+LAT+2 with no stalls.

Test Plan:
- Write entries 0..3 with switch 0 cmd=010/add_en=1/sel=01, others cmd=011, then start N=4 -> o_valid high cycles 1-4; cycles 2-5 show entries 0-3; o_done at cycle 8 (LAT=2); o_busy high cycles 1-7.
- Same setup, i_stall=1 at cycles 2-3 -> o_valid at cycles 1,4,5,6; o_cmd all-zero at cycles 3-4; idx holds at 1; o_done at cycle 10.
- Start N=0 -> no o_valid; o_done at cycle 1; o_busy never asserts.
- Start N=16, then assert i_start and i_cfg_we mid-ISSUE -> second start ignored; table unchanged (read back on rerun); exactly 16 valids, one o_done.
- rst at cycle 3 of an N=8 run -> next cycle all outputs 0, no o_done; a new start with N=2 completes normally with the table reading 0.
- Start with i_num_entries=31 -> clamped to 16 issues.
